// File: rtl/bus_wr_responder.sv
// bus_wr_responder: write-only bus target. Buffers legal (one-hot select)
// writes in a FIFO of FD entries and forwards each, in bus order, to
// exactly one of BSN downstream targets via per-target valid/ready.
// Writes with an illegal select are accepted and dropped.
//
// Optional feature macro: BUS_WR_RESPONDER_ERR_CNT_EN
//   defined   -> saturating count of dropped illegal-select writes on err_cnt
//   undefined -> err_cnt tied to 0
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   bus_wvalid/bus_wready    bus write handshake
//   bus_waddr/wdata/wselct   bus write payload and one-hot target select
//   trg_wvalid/trg_wready    per-target write handshake (one-hot valid)
//   trg_waddr/trg_wdata      payload of the FIFO head
//   err_cnt                  dropped-write counter
module bus_wr_responder #(
  parameter int unsigned BAW = 8,
  parameter int unsigned BDW = 32,
  parameter int unsigned BSN = 4,
  parameter int unsigned FD  = 4,
  parameter int unsigned ECW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           bus_wvalid,
  output logic           bus_wready,
  input  logic [BAW-1:0] bus_waddr,
  input  logic [BDW-1:0] bus_wdata,
  input  logic [BSN-1:0] bus_wselct,
  output logic [BSN-1:0] trg_wvalid,
  input  logic [BSN-1:0] trg_wready,
  output logic [BAW-1:0] trg_waddr,
  output logic [BDW-1:0] trg_wdata,
  output logic [ECW-1:0] err_cnt
);

  localparam int unsigned PW = (FD > 1) ? $clog2(FD) : 1;
  localparam int unsigned CW = PW + 1;

  logic [BSN-1:0] sel_mem  [FD];
  logic [BAW-1:0] addr_mem [FD];
  logic [BDW-1:0] data_mem [FD];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;

  logic legal_c, xfer_c, push_c, pop_c;

  // One-hot select check: non-zero and a single bit set
  always_comb begin
    legal_c = (bus_wselct != '0) && ((bus_wselct & (bus_wselct - BSN'(1))) == '0);
    xfer_c  = bus_wvalid & ready_q;
    push_c  = xfer_c & legal_c;
  end

  // Head presentation straight from registered state; no input-to-output path
  always_comb begin
    trg_wvalid = (count_q != '0) ? sel_mem[rd_ptr_q] : '0;
    trg_waddr  = addr_mem[rd_ptr_q];
    trg_wdata  = data_mem[rd_ptr_q];
    pop_c      = |(trg_wvalid & trg_wready);
  end

  // Next-state for pointers, occupancy and registered ready
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // ready is recomputed from next occupancy so it is a plain flop output
    ready_d = (count_d < CW'(FD));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // FIFO storage; contents are meaningless while count is zero
  always_ff @(posedge clk) begin
    if (push_c) begin
      sel_mem[wr_ptr_q]  <= bus_wselct;
      addr_mem[wr_ptr_q] <= bus_waddr;
      data_mem[wr_ptr_q] <= bus_wdata;
    end
  end

  assign bus_wready = ready_q;

`ifdef BUS_WR_RESPONDER_ERR_CNT_EN
  logic [ECW-1:0] err_q;

  // Saturating count of accepted-but-dropped writes
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else if (xfer_c && !legal_c && (err_q != '1)) begin
      err_q <= err_q + ECW'(1);
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_wr_responder.sv
// Directed bench for bus_wr_responder (ECW=2 so saturation is reachable).
// Inputs change 1 time unit after the rising edge; outputs and handshakes
// are sampled on the falling edge.
module tb_bus_wr_responder;

  localparam int unsigned BAW = 8;
  localparam int unsigned BDW = 32;
  localparam int unsigned BSN = 4;
  localparam int unsigned FD  = 4;
  localparam int unsigned ECW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           bus_wvalid;
  logic           bus_wready;
  logic [BAW-1:0] bus_waddr;
  logic [BDW-1:0] bus_wdata;
  logic [BSN-1:0] bus_wselct;
  logic [BSN-1:0] trg_wvalid;
  logic [BSN-1:0] trg_wready;
  logic [BAW-1:0] trg_waddr;
  logic [BDW-1:0] trg_wdata;
  logic [ECW-1:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BSN+BDW-1:0] got_q[$];

  always #5 clk = ~clk;

  bus_wr_responder #(.BAW(BAW), .BDW(BDW), .BSN(BSN), .FD(FD), .ECW(ECW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_wvalid (bus_wvalid),
    .bus_wready (bus_wready),
    .bus_waddr  (bus_waddr),
    .bus_wdata  (bus_wdata),
    .bus_wselct (bus_wselct),
    .trg_wvalid (trg_wvalid),
    .trg_wready (trg_wready),
    .trg_waddr  (trg_waddr),
    .trg_wdata  (trg_wdata),
    .err_cnt    (err_cnt)
  );

  // Record each target transfer that will complete on the next rising edge
  always @(negedge clk) begin
    if (!rst && |(trg_wvalid & trg_wready)) got_q.push_back({trg_wvalid, trg_wdata});
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one bus write and hold it until accepted (bounded)
  task automatic bus_write(input logic [BAW-1:0] a, input logic [BDW-1:0] d, input logic [BSN-1:0] s);
    logic ok;
    bus_wvalid = 1'b1;
    bus_waddr  = a;
    bus_wdata  = d;
    bus_wselct = s;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = bus_wready;
      @(posedge clk); #1;
      if (ok) begin
        bus_wvalid = 1'b0;
        return;
      end
    end
    bus_wvalid = 1'b0;
    check_eq("write_accept_timeout", 64'd0, 64'd1);
  endtask

  // Wait until the delivery log holds n entries (bounded)
  task automatic wait_got(input int n, input string tag);
    for (int i = 0; i < 100; i++) begin
      if (got_q.size() >= n) return;
      @(negedge clk);
    end
    check_eq(tag, 64'(got_q.size()), 64'(n));
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  logic [ECW-1:0] exp_err2, exp_err5;

  initial begin
`ifdef BUS_WR_RESPONDER_ERR_CNT_EN
    exp_err2 = 2'd2;
    exp_err5 = 2'd3;
`else
    exp_err2 = 2'd0;
    exp_err5 = 2'd0;
`endif
    rst        = 1'b1;
    bus_wvalid = 1'b0;
    bus_waddr  = '0;
    bus_wdata  = '0;
    bus_wselct = '0;
    trg_wready = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_trg_wvalid", 64'(trg_wvalid), 64'h0);
    check_eq("rst_bus_wready", 64'(bus_wready), 64'h1);
    check_eq("rst_err_cnt",    64'(err_cnt),    64'h0);
    tick();

    // Single write, presented one cycle after acceptance, then drained
    trg_wready = 4'b1111;
    got_q.delete();
    bus_write(8'h04, 32'h7654_3210, 4'b0001);
    @(negedge clk);
    check_eq("single_valid", 64'(trg_wvalid), 64'h1);
    check_eq("single_addr",  64'(trg_waddr),  64'h04);
    check_eq("single_data",  64'(trg_wdata),  64'h7654_3210);
    tick();
    @(negedge clk);
    check_eq("single_empty", 64'(trg_wvalid), 64'h0);
    check_eq("single_ready", 64'(bus_wready), 64'h1);
    check_eq("single_count", 64'(got_q.size()), 64'd1);

    // Back-pressure fill: 4 accepted, then full, then drain of 6 in order
    tick();
    trg_wready = '0;
    got_q.delete();
    for (int i = 0; i < 4; i++) bus_write(8'h10, 32'(i), 4'b0010);
    @(negedge clk);
    check_eq("bp_full_ready", 64'(bus_wready), 64'h0);
    check_eq("bp_head_valid", 64'(trg_wvalid), 64'h2);
    check_eq("bp_head_data",  64'(trg_wdata),  64'h0);
    tick();
    fork
      begin
        bus_write(8'h10, 32'd4, 4'b0010);
        bus_write(8'h10, 32'd5, 4'b0010);
      end
      begin
        repeat (2) @(negedge clk);
        check_eq("bp_still_full", 64'(bus_wready), 64'h0);
        tick();
        trg_wready = 4'b0010;
      end
    join
    wait_got(6, "bp_drain_timeout");
    for (int i = 0; i < 6; i++) begin
      if (i < got_q.size()) check_eq($sformatf("bp_order_%0d", i), 64'(got_q[i]), {28'h0, 4'b0010, 32'(i)});
    end

    // Ordering across targets with target 1 stalled
    tick();
    trg_wready = 4'b0001;
    got_q.delete();
    bus_write(8'h20, 32'h10, 4'b0001);
    bus_write(8'h21, 32'h20, 4'b0010);
    bus_write(8'h22, 32'h30, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("ord_stall_head", 64'(trg_wvalid), 64'h2);
      check_eq("ord_stall_count", 64'(got_q.size()), 64'd1);
      tick();
    end
    trg_wready = 4'b0011;
    wait_got(3, "ord_drain_timeout");
    if (got_q.size() == 3) begin
      check_eq("ord_0", 64'(got_q[0]), {28'h0, 4'b0001, 32'h10});
      check_eq("ord_1", 64'(got_q[1]), {28'h0, 4'b0010, 32'h20});
      check_eq("ord_2", 64'(got_q[2]), {28'h0, 4'b0001, 32'h30});
    end

    // Illegal selects are accepted and dropped; counter saturates at 3
    tick();
    trg_wready = 4'b1111;
    got_q.delete();
    bus_write(8'h30, 32'hDEAD, 4'b0000);
    bus_write(8'h31, 32'hBEEF, 4'b0011);
    @(negedge clk);
    check_eq("ill_ready",  64'(bus_wready), 64'h1);
    check_eq("ill_valid",  64'(trg_wvalid), 64'h0);
    check_eq("ill_err2",   64'(err_cnt),    64'(exp_err2));
    tick();
    bus_write(8'h32, 32'h1, 4'b1111);
    bus_write(8'h33, 32'h2, 4'b0101);
    bus_write(8'h34, 32'h3, 4'b0000);
    @(negedge clk);
    check_eq("ill_err_sat",   64'(err_cnt),       64'(exp_err5));
    check_eq("ill_none_sent", 64'(got_q.size()),  64'd0);

    // Reset mid-operation discards buffered writes
    tick();
    trg_wready = '0;
    bus_write(8'h40, 32'hA, 4'b0100);
    bus_write(8'h41, 32'hB, 4'b0100);
    bus_write(8'h42, 32'hC, 4'b0100);
    @(negedge clk);
    check_eq("mid_pre_valid", 64'(trg_wvalid), 64'h4);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got_q.delete();
    @(negedge clk);
    check_eq("mid_valid", 64'(trg_wvalid), 64'h0);
    check_eq("mid_ready", 64'(bus_wready), 64'h1);
    check_eq("mid_err",   64'(err_cnt),    64'h0);
    tick();
    trg_wready = 4'b1111;
    repeat (10) @(negedge clk);
    check_eq("mid_no_delivery", 64'(got_q.size()), 64'd0);
    check_eq("mid_idle_valid",  64'(trg_wvalid),   64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
